// File: rtl/key_expansion_ctrl_if.sv
// -----------------------------------------------------------------------------
// key_expansion_ctrl_if
//   Bundles the control and read-port signals of the iterative AES-128
//   key-expansion sequencer.
//
//   master modport (key consumer / cipher round engine side):
//     start, key_in       request expansion of a new cipher key
//     rd_en, rd_round     random-access read of a stored round key
//     busy, done          expansion status (done is a one-cycle pulse)
//     keys_valid          bank holds a complete schedule
//     rd_key, rd_valid,   registered read response (one cycle after rd_en)
//     rd_err
//   slave modport: the key_expansion_ctrl itself.
// -----------------------------------------------------------------------------
interface key_expansion_ctrl_if #(
    parameter int KEY_W = 128
);
    logic             start;
    logic [0:KEY_W-1] key_in;
    logic             busy;
    logic             done;
    logic             keys_valid;
    logic             rd_en;
    logic [3:0]       rd_round;
    logic [0:KEY_W-1] rd_key;
    logic             rd_valid;
    logic             rd_err;

    modport master (
        output start, key_in, rd_en, rd_round,
        input  busy, done, keys_valid, rd_key, rd_valid, rd_err
    );

    modport slave (
        input  start, key_in, rd_en, rd_round,
        output busy, done, keys_valid, rd_key, rd_valid, rd_err
    );
endinterface

// File: rtl/key_expansion_ctrl.sv
// -----------------------------------------------------------------------------
// key_expansion_ctrl
//   Iterative AES-128 key-expansion sequencer. A single combinational
//   key_maker round stage is reused over rounds 1..10, producing one round key
//   per clock into an 11 x 128 bank (key0..key10). The bank is read through a
//   registered random-access port by the cipher round engine.
//
//   Ports:
//     clk      rising-edge clock
//     rst      asynchronous, active-high reset
//     bus      key_expansion_ctrl_if.slave
//                start/key_in   begin expansion (accepted only in IDLE)
//                busy           expansion in progress
//                done           one-cycle pulse after key10 is written
//                keys_valid     bank holds a complete schedule
//                rd_en/rd_round read request, index 0..10
//                rd_key         registered read data (0 on a rejected read)
//                rd_valid       response strobe, one cycle after rd_en
//                rd_err         read rejected (index > 10 or !keys_valid)
//
//   Key bit order is big-endian: bit 0 is the MSB of byte 0.
// -----------------------------------------------------------------------------
module key_expansion_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_W      = 128
) (
    input logic                 clk,
    input logic                 rst,
    key_expansion_ctrl_if.slave bus
);

    generate
        if (NUM_ROUNDS != 10 || KEY_W != 128) begin : g_param_check
            $error("key_expansion_ctrl supports only AES-128 (NUM_ROUNDS=10, KEY_W=128)");
        end
    endgenerate

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    // AES forward S-box, entry n occupies bits [8n +: 8].
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic logic [0:7] sbox(input logic [0:7] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [0:31] sub_word(input logic [0:31] w);
        return {sbox(w[0:7]), sbox(w[8:15]), sbox(w[16:23]), sbox(w[24:31])};
    endfunction

    function automatic logic [0:7] rcon(input logic [3:0] r);
        logic [0:7] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // One AES-128 key-schedule round: previous round key -> next round key.
    function automatic logic [0:127] key_maker(input logic [0:127] k, input logic [3:0] r);
        logic [0:31] w0, w1, w2, w3, t, n0, n1, n2, n3;
        w0 = k[0:31];
        w1 = k[32:63];
        w2 = k[64:95];
        w3 = k[96:127];
        t  = sub_word({w3[8:31], w3[0:7]});
        t[0:7] = t[0:7] ^ rcon(r);
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    state_t       state, state_next;
    logic [3:0]   rnd, rnd_next;
    logic         keys_valid_q, keys_valid_next;
    logic         load_c;
    logic         wr_en_c;
    logic         busy_c;
    logic         done_c;

    logic [0:127] cur_key_p0;
    logic [0:127] next_key_p0;
    logic [0:127] bank [0:10];

    logic         rd_ok_c;
    logic [3:0]   rd_idx_c;
    logic         vld_p1;
    logic         rd_err_p1;
    logic [0:127] rd_key_p1;

    assign next_key_p0 = key_maker(cur_key_p0, rnd);

    // ---- stage p0: sequencer FSM --------------------------------------------
    always_comb begin
        state_next      = state;
        rnd_next        = rnd;
        keys_valid_next = keys_valid_q;
        load_c          = 1'b0;
        wr_en_c         = 1'b0;
        busy_c          = 1'b0;
        done_c          = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load_c          = 1'b1;
                    state_next      = EXPAND;
                    rnd_next        = 4'd1;
                    keys_valid_next = 1'b0;
                end
            end
            EXPAND: begin
                if (rnd >= 4'd1 && rnd <= LAST_RND) begin
                    busy_c  = 1'b1;
                    wr_en_c = 1'b1;
                    if (rnd == LAST_RND) begin
                        state_next      = DONE;
                        rnd_next        = 4'd0;
                        keys_valid_next = 1'b1;
                    end else begin
                        rnd_next = rnd + 4'd1;
                    end
                end else begin
                    // Out-of-range counter cannot occur; fall back to IDLE.
                    state_next = IDLE;
                    rnd_next   = 4'd0;
                end
            end
            DONE: begin
                done_c     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                rnd_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rnd          <= 4'd0;
            keys_valid_q <= 1'b0;
        end else begin
            state        <= state_next;
            rnd          <= rnd_next;
            keys_valid_q <= keys_valid_next;
        end
    end

    // Key datapath and bank carry no reset: they are unobservable until
    // keys_valid rises after a full expansion.
    always_ff @(posedge clk) begin
        if (load_c) begin
            bank[0]    <= bus.key_in;
            cur_key_p0 <= bus.key_in;
        end else if (wr_en_c) begin
            bank[rnd]  <= next_key_p0;
            cur_key_p0 <= next_key_p0;
        end
    end

    // ---- stage p1: registered read port ------------------------------------
    // The read sees keys_valid and bank contents as they were before the edge,
    // so a read coinciding with a start returns the previous schedule.
    assign rd_ok_c  = keys_valid_q && (bus.rd_round <= LAST_RND);
    assign rd_idx_c = rd_ok_c ? bus.rd_round : 4'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            rd_err_p1 <= 1'b0;
            rd_key_p1 <= '0;
        end else begin
            vld_p1 <= bus.rd_en;
            if (bus.rd_en) begin
                if (rd_ok_c) begin
                    rd_key_p1 <= bank[rd_idx_c];
                    rd_err_p1 <= 1'b0;
                end else begin
                    rd_key_p1 <= '0;
                    rd_err_p1 <= 1'b1;
                end
            end else begin
                rd_err_p1 <= 1'b0;
            end
        end
    end

    assign bus.busy       = busy_c;
    assign bus.done       = done_c;
    assign bus.keys_valid = keys_valid_q;
    assign bus.rd_key     = rd_key_p1;
    assign bus.rd_valid   = vld_p1;
    assign bus.rd_err     = rd_err_p1;

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_expansion_ctrl
//   Self-checking bench for key_expansion_ctrl. The reference keeps the full
//   key schedule computed word-by-word as in FIPS-197 (S-box derived from GF(2^8)
//   inversion plus the affine map) and an abstract timing model: an accepted
//   start makes the schedule readable exactly ten edges later.
// -----------------------------------------------------------------------------
module tb_key_expansion_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_expansion_ctrl_if #(.KEY_W(128)) bus ();

    key_expansion_ctrl #(
        .NUM_ROUNDS(10),
        .KEY_W     (128)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A_R1    = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A_R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_R10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_t [0:255];
    logic [127:0] m_keys [0:10];
    logic [127:0] m_pend [0:10];
    int           m_busy;
    bit           m_done, m_kv, m_rv, m_re;
    logic [127:0] m_rk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
            sbox_t[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // FIPS-197 KeyExpansion for Nk=4: fills m_pend with round keys 0..10.
    task automatic expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) m_pend[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".busy"},       128'(bus.busy),       128'(m_busy > 0));
        chk({tag, ".done"},       128'(bus.done),       128'(m_done));
        chk({tag, ".keys_valid"}, 128'(bus.keys_valid), 128'(m_kv));
        chk({tag, ".rd_valid"},   128'(bus.rd_valid),   128'(m_rv));
        chk({tag, ".rd_err"},     128'(bus.rd_err),     128'(m_re));
        chk({tag, ".rd_key"},     bus.rd_key,           m_rk);
    endtask

    // One clock: drive inputs, advance the reference across the edge, compare.
    task automatic step(input bit s, input logic [127:0] k, input bit re, input logic [3:0] rr);
        bit nd;
        bus.start    = s;
        bus.key_in   = k;
        bus.rd_en    = re;
        bus.rd_round = rr;
        if (re) begin
            m_rv = 1'b1;
            if (m_kv && rr <= 4'd10) begin
                m_rk = m_keys[rr];
                m_re = 1'b0;
            end else begin
                m_rk = '0;
                m_re = 1'b1;
            end
        end else begin
            m_rv = 1'b0;
            m_re = 1'b0;
        end
        nd = 1'b0;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                nd     = 1'b1;
                m_kv   = 1'b1;
                m_keys = m_pend;
            end
        end else if (s && !m_done) begin
            expand(k);
            m_busy = 10;
            m_kv   = 1'b0;
        end
        m_done = nd;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.rd_en = 1'b0;
        check_outputs("step");
    endtask

    // Steps with idle inputs until done; latency counted from the start edge.
    task automatic wait_done(input string tag);
        int n;
        for (n = 1; n <= 20; n++) begin
            step(1'b0, '0, 1'b0, 4'd0);
            if (bus.done === 1'b1) break;
        end
        chk({tag, ".latency"}, 128'(n), 128'(10));
    endtask

    task automatic sweep(input string tag);
        int cnt;
        cnt = 0;
        for (int r = 0; r <= 10; r++) begin
            step(1'b0, '0, 1'b1, 4'(r));
            if (bus.rd_valid === 1'b1 && bus.rd_err === 1'b0) cnt++;
        end
        chk({tag, ".valid_count"}, 128'(cnt), 128'(11));
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        m_busy = 0;
        m_done = 1'b0;
        m_kv   = 1'b0;
        m_rv   = 1'b0;
        m_re   = 1'b0;
        m_rk   = '0;
        check_outputs(tag);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int first, cnt;
        logic [127:0] k1, k2, kr;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.key_in   = '0;
        bus.rd_en    = 1'b0;
        bus.rd_round = 4'd0;
        m_busy = 0; m_done = 1'b0; m_kv = 1'b0; m_rv = 1'b0; m_re = 1'b0; m_rk = '0;
        build_sbox();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b0;

        // FIPS-197 A.1 known answers
        step(1'b1, KEY_A, 1'b0, 4'd0);
        wait_done("a1");
        step(1'b0, '0, 1'b1, 4'd1);
        chk("a1.round1", bus.rd_key, A_R1);
        step(1'b0, '0, 1'b1, 4'd10);
        chk("a1.round10", bus.rd_key, A_R10);
        step(1'b0, '0, 1'b1, 4'd0);
        chk("a1.round0", bus.rd_key, KEY_A);

        // Full sweep, out-of-range indices, hold on idle
        sweep("a1_sweep");
        step(1'b0, '0, 1'b1, 4'd11);
        step(1'b0, '0, 1'b1, 4'd15);
        step(1'b0, '0, 1'b1, 4'd5);
        step(1'b0, '0, 1'b0, 4'd0);
        chk("a1.hold", bus.rd_key, m_keys[5]);

        // Restart with concurrent read (old schedule), ignored starts, read while expanding
        k1 = {$urandom, $urandom, $urandom, $urandom};
        step(1'b1, k1, 1'b1, 4'd5);
        chk("restart.kv_clear", 128'(bus.keys_valid), 128'(0));
        first = 0;
        cnt   = 0;
        for (int i = 1; i <= 12; i++) begin
            step((i == 3 || i == 9), ~k1, (i == 4), 4'd2);
            if (i == 4) chk("expand_read.err", 128'(bus.rd_err), 128'(1));
            if (bus.done === 1'b1) begin
                cnt++;
                if (first == 0) first = i;
            end
        end
        chk("ignore.done_count", 128'(cnt), 128'(1));
        chk("ignore.done_cycle", 128'(first), 128'(10));
        sweep("k1_sweep");

        // Reset mid-expansion, then all-zero key
        k2 = {$urandom, $urandom, $urandom, $urandom};
        step(1'b1, k2, 1'b0, 4'd0);
        repeat (5) step(1'b0, '0, 1'b0, 4'd0);
        async_reset("mid_rst");
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, '0, (i == 6), 4'd3);
            if (bus.done === 1'b1) cnt++;
        end
        chk("mid_rst.no_done", 128'(cnt), 128'(0));
        step(1'b1, '0, 1'b0, 4'd0);
        wait_done("zero");
        step(1'b0, '0, 1'b1, 4'd10);
        chk("zero.round10", bus.rd_key, Z_R10);

        // Random keys with random read traffic and stray start pulses
        for (int it = 0; it < 200; it++) begin
            kr = {$urandom, $urandom, $urandom, $urandom};
            step(1'b1, kr, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            first = 0;
            for (int n = 1; n <= 20; n++) begin
                step(($urandom_range(0, 7) == 0), {$urandom, $urandom, $urandom, $urandom},
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
                if (bus.done === 1'b1) begin
                    first = n;
                    break;
                end
            end
            chk("rand.latency", 128'(first), 128'(10));
            repeat ($urandom_range(1, 4))
                step(1'b0, '0, 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 12)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
